// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: NCH packed channels with stall (hold), flush (bubble)
// and reset, plus a load pulse, a held-cycle counter and a saturating stall total.
module pipe_stage_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NCH     = 6,
    parameter int unsigned PC_CH   = 1,
    parameter int unsigned KEEP_PC = 1
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   we,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [NCH*WIDTH-1:0]   in_bus,
    output logic [NCH*WIDTH-1:0]   out_bus,
    output logic                   out_valid,
    output logic                   out_new,
    output logic [7:0]             hold_cnt,
    output logic [15:0]            stall_total
);

    logic [NCH*WIDTH-1:0] r_bus;
    logic                 r_valid;
    logic                 r_new;
    logic [7:0]           r_hold;
    logic [15:0]          r_stall;

    logic [NCH*WIDTH-1:0] w_flush_bus;
    logic                 w_hold_sat;
    logic                 w_stall_sat;

    // Bubble contents: all zero, except the PC channel optionally follows in_bus
    always_comb begin
        w_flush_bus = '0;
        if (KEEP_PC != 0) begin
            w_flush_bus[PC_CH*WIDTH +: WIDTH] = in_bus[PC_CH*WIDTH +: WIDTH];
        end
    end

    assign w_hold_sat  = (r_hold == '1);
    assign w_stall_sat = (r_stall == '1);

    always_ff @(posedge clk) begin
        if (res) begin
            r_bus   <= '0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
            r_hold  <= '0;
            r_stall <= '0;
        end else if (flush) begin
            r_bus   <= w_flush_bus;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
            r_hold  <= '0;
        end else if (!we) begin
            r_new <= 1'b0;
            // Counters only advance while a real instruction is being held
            if (r_valid) begin
                if (!w_hold_sat) begin
                    r_hold <= r_hold + 8'd1;
                end
                if (!w_stall_sat) begin
                    r_stall <= r_stall + 16'd1;
                end
            end
        end else begin
            r_bus   <= in_bus;
            r_valid <= in_valid;
            r_new   <= in_valid;
            r_hold  <= '0;
        end
    end

    assign out_bus     = r_bus;
    assign out_valid   = r_valid;
    assign out_new     = r_new;
    assign hold_cnt    = r_hold;
    assign stall_total = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance, KEEP_PC=0 instance and a
// single-channel instance share the same stimulus.
module tb_pipe_stage_reg;

    localparam int unsigned BW = 192;
    typedef logic [BW-1:0] vec_t;

    logic        clk = 1'b0;
    logic        res, we, flush, in_valid;
    logic [191:0] in_bus;

    logic [191:0] out_bus0, out_bus1;
    logic [31:0]  out_bus2;
    logic         out_valid0, out_valid1, out_valid2;
    logic         out_new0, out_new1, out_new2;
    logic [7:0]   hold_cnt0, hold_cnt1, hold_cnt2;
    logic [15:0]  stall_total0, stall_total1, stall_total2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .NCH(6), .PC_CH(1), .KEEP_PC(1)) dut0 (
        .clk(clk), .res(res), .we(we), .flush(flush), .in_valid(in_valid),
        .in_bus(in_bus), .out_bus(out_bus0), .out_valid(out_valid0),
        .out_new(out_new0), .hold_cnt(hold_cnt0), .stall_total(stall_total0)
    );

    pipe_stage_reg #(.WIDTH(32), .NCH(6), .PC_CH(1), .KEEP_PC(0)) dut1 (
        .clk(clk), .res(res), .we(we), .flush(flush), .in_valid(in_valid),
        .in_bus(in_bus), .out_bus(out_bus1), .out_valid(out_valid1),
        .out_new(out_new1), .hold_cnt(hold_cnt1), .stall_total(stall_total1)
    );

    pipe_stage_reg #(.WIDTH(32), .NCH(1), .PC_CH(0), .KEEP_PC(1)) dut2 (
        .clk(clk), .res(res), .we(we), .flush(flush), .in_valid(in_valid),
        .in_bus(in_bus[31:0]), .out_bus(out_bus2), .out_valid(out_valid2),
        .out_new(out_new2), .hold_cnt(hold_cnt2), .stall_total(stall_total2)
    );

    function automatic vec_t mk(input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input logic [31:0] c4, input logic [31:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t held;

        res = 1'b1; we = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_bus = mk(32'hDEADBEEF, 32'h12345678, 32'h1, 32'h2, 32'h3, 32'h4);
        step();
        chk("rst_bus",   vec_t'(out_bus0), '0);
        chk("rst_valid", vec_t'(out_valid0), '0);
        chk("rst_new",   vec_t'(out_new0), '0);
        chk("rst_hold",  vec_t'(hold_cnt0), '0);
        chk("rst_stall", vec_t'(stall_total0), '0);
        chk("rst_bus2",  vec_t'(out_bus2), '0);

        // Basic load
        res = 1'b0; we = 1'b1; in_valid = 1'b1;
        in_bus = mk(32'h24080005, 32'h00003004, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("load_bus",   vec_t'(out_bus0), mk(32'h24080005, 32'h00003004, 0, 0, 0, 0));
        chk("load_valid", vec_t'(out_valid0), vec_t'(1));
        chk("load_new",   vec_t'(out_new0), vec_t'(1));
        chk("load_bus2",  vec_t'(out_bus2), vec_t'(32'h24080005));
        in_valid = 1'b0;
        in_bus = mk(32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA);
        step();
        chk("inv_new",   vec_t'(out_new0), '0);
        chk("inv_valid", vec_t'(out_valid0), '0);
        chk("inv_bus",   vec_t'(out_bus0), mk(32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA));

        // Stall for three cycles while in_bus keeps changing
        in_valid = 1'b1;
        held = mk(32'h11, 32'h00003008, 32'h22, 32'h33, 32'h44, 32'h55);
        in_bus = held;
        step();
        chk("stl_new0", vec_t'(out_new0), vec_t'(1));
        chk("stl_hold0", vec_t'(hold_cnt0), '0);
        we = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_bus = mk(32'(i), 32'(i * 4), 32'hF0, 32'hF1, 32'hF2, 32'hF3);
            step();
            chk("stl_bus",   vec_t'(out_bus0), held);
            chk("stl_hold",  vec_t'(hold_cnt0), vec_t'(i));
            chk("stl_stall", vec_t'(stall_total0), vec_t'(i));
            chk("stl_new",   vec_t'(out_new0), '0);
        end
        we = 1'b1;
        in_bus = mk(32'h1, 32'h0000300C, 32'h2, 32'h3, 32'h4, 32'h5);
        step();
        chk("stl_release_hold",  vec_t'(hold_cnt0), '0);
        chk("stl_release_stall", vec_t'(stall_total0), vec_t'(3));

        // Hold while the slot is empty leaves counters alone
        in_valid = 1'b0;
        step();
        we = 1'b0;
        step();
        chk("empty_hold",  vec_t'(hold_cnt0), '0);
        chk("empty_stall", vec_t'(stall_total0), vec_t'(3));
        chk("empty_valid", vec_t'(out_valid0), '0);

        // Flush together with a stall
        we = 1'b1; in_valid = 1'b1;
        in_bus = mk(32'h11111111, 32'h00003010, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555);
        step();
        flush = 1'b1; we = 1'b0;
        in_bus = mk(32'hAAAAAAAA, 32'h0000300C, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE);
        step();
        chk("fl_bus_keep",  vec_t'(out_bus0), mk(0, 32'h0000300C, 0, 0, 0, 0));
        chk("fl_valid",     vec_t'(out_valid0), '0);
        chk("fl_new",       vec_t'(out_new0), '0);
        chk("fl_hold",      vec_t'(hold_cnt0), '0);
        chk("fl_stall",     vec_t'(stall_total0), vec_t'(3));
        chk("fl_bus_nokeep", vec_t'(out_bus1), '0);
        chk("fl_valid_nokeep", vec_t'(out_valid1), '0);
        chk("fl_bus_1ch",   vec_t'(out_bus2), vec_t'(32'hAAAAAAAA));
        chk("fl_valid_1ch", vec_t'(out_valid2), '0);
        we = 1'b1;
        in_bus = mk(32'h1, 32'h00003020, 32'h2, 32'h3, 32'h4, 32'h5);
        step();
        chk("fl_over_load_bus",   vec_t'(out_bus0), mk(0, 32'h00003020, 0, 0, 0, 0));
        chk("fl_over_load_valid", vec_t'(out_valid0), '0);
        flush = 1'b0;

        // Saturation of hold_cnt and stall_total
        res = 1'b1;
        step();
        res = 1'b0; we = 1'b1; in_valid = 1'b1;
        held = mk(32'h1234, 32'h00004000, 32'h5678, 32'h9ABC, 32'hDEF0, 32'h1357);
        in_bus = held;
        step();
        we = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 254) chk("sat_hold_254", vec_t'(hold_cnt0), vec_t'(254));
            if (i == 255) chk("sat_hold_255", vec_t'(hold_cnt0), vec_t'(255));
        end
        chk("sat_hold_300",  vec_t'(hold_cnt0), vec_t'(255));
        chk("sat_stall_300", vec_t'(stall_total0), vec_t'(300));
        chk("sat_stall_300_nokeep", vec_t'(stall_total1), vec_t'(300));
        chk("sat_bus",       vec_t'(out_bus0), held);
        for (int i = 301; i <= 70000; i++) begin
            step();
            if (i == 65534) chk("sat_stall_65534", vec_t'(stall_total0), vec_t'(65534));
            if (i == 65535) chk("sat_stall_65535", vec_t'(stall_total0), vec_t'(65535));
        end
        chk("sat_stall_70000", vec_t'(stall_total0), vec_t'(65535));
        chk("sat_hold_70000",  vec_t'(hold_cnt0), vec_t'(255));

        // Reset overrides everything in the middle of a hold
        res = 1'b1; flush = 1'b1; we = 1'b1; in_valid = 1'b1;
        in_bus = mk(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
        step();
        chk("rp_bus",    vec_t'(out_bus0), '0);
        chk("rp_valid",  vec_t'(out_valid0), '0);
        chk("rp_new",    vec_t'(out_new0), '0);
        chk("rp_hold",   vec_t'(hold_cnt0), '0);
        chk("rp_stall",  vec_t'(stall_total0), '0);
        chk("rp_bus2",   vec_t'(out_bus2), '0);

        // First edge out of reset acts on the current inputs
        res = 1'b0; flush = 1'b0;
        in_bus = mk(32'hCAFE0001, 32'h00005000, 32'h3, 32'h4, 32'h5, 32'h6);
        step();
        chk("post_rst_bus",   vec_t'(out_bus0), mk(32'hCAFE0001, 32'h00005000, 32'h3, 32'h4, 32'h5, 32'h6));
        chk("post_rst_new",   vec_t'(out_new0), vec_t'(1));
        chk("post_rst_valid", vec_t'(out_valid1), vec_t'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the bit width of one channel.
REQ-002 The block SHALL have parameter NCH, default 6, giving the number of channels (legal 1..16).
REQ-003 The block SHALL have parameter PC_CH, default 1, giving the index of the PC channel (legal 0..NCH-1).
REQ-004 The block SHALL have parameter KEEP_PC, default 1; when 1, the PC channel is loaded on flush, and when 0, it is zeroed on flush.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port we, input, 1 bit: stage write enable; 0 means stall (hold).
REQ-008 The block SHALL have port flush, input, 1 bit: insert a bubble.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the upstream instruction is real.
REQ-010 The block SHALL have port in_bus, input, NCH*WIDTH bits: upstream channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port out_bus, output, NCH*WIDTH bits: registered channels, same packing as in_bus.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the registered slot holds a real instruction.
REQ-013 The block SHALL have port out_new, output, 1 bit: one-cycle pulse after a valid load.
REQ-014 The block SHALL have port hold_cnt, output, 8 bits: consecutive cycles the current valid content has been held.
REQ-015 The block SHALL have port stall_total, output, 16 bits: saturating count of cycles with we=0 and out_valid=1.

Function
REQ-016 Per rising edge, the block SHALL apply exactly one action, in priority order res > flush > hold (we=0) > load (we=1).
REQ-017 Load: out_bus SHALL take in_bus, out_valid SHALL take in_valid, and hold_cnt SHALL become 0.
REQ-018 Hold: out_bus and out_valid SHALL keep their values, and no channel SHALL change.
REQ-019 Flush: every channel except PC_CH SHALL become 0, and out_valid SHALL become 0.
REQ-020 On flush, the PC_CH channel SHALL take in_bus channel PC_CH when KEEP_PC=1, else become 0.
REQ-021 flush SHALL override we=0: flush together with a stall SHALL still produce a bubble, with PC handled per REQ-020.
REQ-022 out_new SHALL be 1 exactly in the cycle after a load with in_valid=1, and 0 otherwise, including after hold, flush and res.
REQ-023 hold_cnt SHALL increment by 1 on a hold edge while out_valid=1, saturate at 255, and become 0 on load, flush or res.
REQ-024 hold_cnt SHALL stay unchanged on a hold edge while out_valid=0.
REQ-025 stall_total SHALL increment by 1 on each hold edge with out_valid=1, saturate at 65535, and never wrap.
REQ-026 stall_total SHALL be unaffected by flush and load, and cleared only by res.
REQ-027 Load latency SHALL be one cycle: in_bus sampled at edge N SHALL appear on out_bus after edge N.
REQ-028 There SHALL be no combinational path from any input to any output; all outputs SHALL be register-driven.
REQ-029 With NCH=1 and PC_CH=0, flush SHALL follow REQ-020 for the single channel.

Reset
REQ-030 On a res=1 edge, out_bus (every channel, including PC_CH regardless of KEEP_PC) SHALL become 0.
REQ-031 On a res=1 edge, out_valid, out_new, hold_cnt and stall_total SHALL become 0.
REQ-032 res=1 SHALL override we, flush and in_valid in the same cycle.
REQ-033 Reset in the middle of a hold SHALL discard the held content and the counts.
REQ-034 The first edge with res=0 SHALL act per REQ-016 using the current inputs.

Verification
REQ-035 Load: res then we=1, in_valid=1, channel1=0x00003004, channel0=0x24080005 -> next cycle out_bus matches, out_valid=1, out_new=1 for one cycle only.
REQ-036 Stall: load 0x00003008 on the PC channel, then we=0 for 3 cycles with in_bus changing -> out_bus constant, hold_cnt 1,2,3, stall_total=3; then we=1 -> hold_cnt=0.
REQ-037 Flush with stall, KEEP_PC=1: flush=1, we=0, PC input 0x0000300C -> out_valid=0, PC channel=0x0000300C, all others 0, out_new=0.
REQ-038 Flush with KEEP_PC=0: same stimulus as REQ-037 -> all channels 0.
REQ-039 Saturation: hold 300 cycles with out_valid=1 -> hold_cnt=255 and stall_total=300; force 70000 stall cycles -> stall_total=65535.
REQ-040 Reset priority: res=1 with flush=1, we=1, in_valid=1 mid-hold -> all outputs 0 next cycle.
